// File: rtl/rst_sequencer.sv
// rst_sequencer: power-on and lock-loss reset sequencer.
// Runs on the free-running EPB clock. It waits for MMCM lock and qualifies it.
// It then pulses the IDELAYCTRL reset, waits for IDELAYCTRL ready, and releases sys_rst.
// If lock never arrives, the MMCM is reset and the sequence retries.
// Lock losses seen while running are counted, saturating at 255.
//
// Build option: define RST_SEQ_SOFT_RST_EN to add the soft_rst_req input.
// A soft request forces an MMCM reset from any state except RESET and MMCM_RST.
// The default build has no soft-reset port or logic.
//
// Every output is registered from the next-state value. Each output therefore
// equals a decode of the state register, and no input has a combinational path
// to an output.
module rst_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MMCM_RST_CYCLES     = 16,
  parameter int unsigned IDELAY_RST_CYCLES   = 16,
  parameter int unsigned RDY_TIMEOUT_CYCLES  = 4096
) (
  input  logic       epb_clk,
  input  logic       epb_rst_n,
  input  logic       mmcm_locked,
  input  logic       idelay_rdy,
`ifdef RST_SEQ_SOFT_RST_EN
  input  logic       soft_rst_req,
`endif
  output logic       mmcm_rst,
  output logic       idelay_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  // Larger of two cycle parameters, used to size the shared counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC =
    max_u(max_u(max_u(LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES),
                max_u(MMCM_RST_CYCLES, IDELAY_RST_CYCLES)),
          RDY_TIMEOUT_CYCLES);

  // The counter only has to reach MAX_CYC-1, because every terminal compare is at N-1.
  localparam int unsigned CNT_W = (MAX_CYC > 32'd1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES  - 32'd1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] MMCM_LAST    = CNT_W'(MMCM_RST_CYCLES     - 32'd1);
  localparam logic [CNT_W-1:0] IDLY_LAST    = CNT_W'(IDELAY_RST_CYCLES   - 32'd1);
  localparam logic [CNT_W-1:0] RDY_LAST     = CNT_W'(RDY_TIMEOUT_CYCLES  - 32'd1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_MMCM_RST  = 3'd2,
    ST_STABLE    = 3'd3,
    ST_IDLY_RST  = 3'd4,
    ST_WAIT_RDY  = 3'd5,
    ST_RUN       = 3'd6
  } state_e;

  // Output decode for a state: {mmcm_rst, idelay_rst, sys_rst, ready}.
  function automatic logic [3:0] decode_outputs(input state_e s);
    logic [3:0] o;
    case (s)
      ST_MMCM_RST: o = 4'b1010;
      ST_IDLY_RST: o = 4'b0110;
      ST_RUN:      o = 4'b0001;
      default:     o = 4'b0010;
    endcase
    return o;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lock_sync_q, rdy_sync_q;
  logic             lock_s, rdy_s;
  logic             lost_d;
  logic             mmcm_rst_q, idelay_rst_q, sys_rst_q, ready_q;
  logic [7:0]       lock_loss_q;

  // Two-flop synchronisers for the asynchronous lock and ready inputs.
  always_ff @(posedge epb_clk or negedge epb_rst_n) begin
    if (!epb_rst_n) begin
      lock_sync_q <= 2'b00;
      rdy_sync_q  <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], mmcm_locked};
      rdy_sync_q  <= {rdy_sync_q[0], idelay_rdy};
    end
  end

  assign lock_s = lock_sync_q[1];
  assign rdy_s  = rdy_sync_q[1];

  // Next-state logic, lock-loss detection, and the shared counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_MMCM_RST;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_MMCM_RST: begin
        // Lock is deliberately ignored while the MMCM is held in reset.
        if (cnt_q == MMCM_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_MMCM_RST;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_IDLY_RST;
        end else begin
          state_d = ST_STABLE;
        end
      end
      ST_IDLY_RST: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == IDLY_LAST) begin
          state_d = ST_WAIT_RDY;
        end else begin
          state_d = ST_IDLY_RST;
        end
      end
      ST_WAIT_RDY: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (rdy_s) begin
          state_d = ST_RUN;
        end else if (cnt_q == RDY_LAST) begin
          state_d = ST_IDLY_RST;
        end else begin
          state_d = ST_WAIT_RDY;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          lost_d  = 1'b1;
        end else if (!rdy_s) begin
          state_d = ST_IDLY_RST;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

`ifdef RST_SEQ_SOFT_RST_EN
    // A soft request wins over every other transition and is never counted as a lock loss.
    if (soft_rst_req && (state_q != ST_RESET) && (state_q != ST_MMCM_RST)) begin
      state_d = ST_MMCM_RST;
      lost_d  = 1'b0;
    end else begin
      state_d = state_d;
    end
`endif

    // Clear on every state change. Hold in RUN and RESET, where no timing is needed.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_RESET)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Sequencer state, counter, registered Moore outputs and the saturating lock-loss count.
  always_ff @(posedge epb_clk or negedge epb_rst_n) begin
    if (!epb_rst_n) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      mmcm_rst_q   <= 1'b0;
      idelay_rst_q <= 1'b0;
      sys_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      lock_loss_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      {mmcm_rst_q, idelay_rst_q, sys_rst_q, ready_q} <= decode_outputs(state_d);
      if (lost_d && (lock_loss_q != 8'hFF)) begin
        lock_loss_q <= lock_loss_q + 8'd1;
      end else begin
        lock_loss_q <= lock_loss_q;
      end
    end
  end

  assign mmcm_rst      = mmcm_rst_q;
  assign idelay_rst    = idelay_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = lock_loss_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer.
// Expected values are pushed to a scoreboard queue when stimulus is applied.
// They are popped and compared when the DUT output is sampled.
// The soft-reset scenario is built only when RST_SEQ_SOFT_RST_EN is defined.
module tb_rst_sequencer;

  localparam int unsigned LS = 8;
  localparam int unsigned LT = 32;
  localparam int unsigned MR = 4;
  localparam int unsigned IR = 4;
  localparam int unsigned RT = 16;

  logic       epb_clk = 1'b0;
  logic       epb_rst_n;
  logic       mmcm_locked;
  logic       idelay_rdy;
`ifdef RST_SEQ_SOFT_RST_EN
  logic       soft_rst_req;
`endif
  logic       mmcm_rst;
  logic       idelay_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mmcm_hi = 0;
  int exp_q[$];

  rst_sequencer #(
    .LOCK_STABLE_CYCLES (LS),
    .LOCK_TIMEOUT_CYCLES(LT),
    .MMCM_RST_CYCLES    (MR),
    .IDELAY_RST_CYCLES  (IR),
    .RDY_TIMEOUT_CYCLES (RT)
  ) dut (
    .epb_clk      (epb_clk),
    .epb_rst_n    (epb_rst_n),
    .mmcm_locked  (mmcm_locked),
    .idelay_rdy   (idelay_rdy),
`ifdef RST_SEQ_SOFT_RST_EN
    .soft_rst_req (soft_rst_req),
`endif
    .mmcm_rst     (mmcm_rst),
    .idelay_rst   (idelay_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 epb_clk = ~epb_clk;

  // Cycle counter for latency and width measurements.
  always @(posedge epb_clk) cyc <= cyc + 1;

  // Count the cycles that mmcm_rst is high, sampled on the opposite edge.
  always @(negedge epb_clk) if (mmcm_rst) mmcm_hi <= mmcm_hi + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input int obs);
    int e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, obs, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge epb_clk);
      #1;
    end
  endtask

  function automatic logic out_sig(input int sel);
    case (sel)
      0:       return mmcm_rst;
      1:       return idelay_rst;
      2:       return sys_rst;
      default: return ready;
    endcase
  endfunction

  // Wait until the selected output reaches val. Running out of budget counts as a failure.
  task automatic wait_lvl(input string tag, input int sel, input logic val, input int budget);
    int n;
    n = 0;
    while ((out_sig(sel) !== val) && (n < budget)) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_reached"}, int'(out_sig(sel) === val), 1);
  endtask

  // Hold reset, check the reset values, then release just after an edge.
  task automatic apply_reset(input logic lock, input logic rdy);
    epb_rst_n   = 1'b0;
    mmcm_locked = lock;
    idelay_rdy  = rdy;
    tick(3);
    sb_push(0); sb_check("rst_mmcm_rst", int'(mmcm_rst));
    sb_push(0); sb_check("rst_idelay_rst", int'(idelay_rst));
    sb_push(1); sb_check("rst_sys_rst", int'(sys_rst));
    sb_push(0); sb_check("rst_ready", int'(ready));
    sb_push(0); sb_check("rst_lock_loss", int'(lock_loss_cnt));
    epb_rst_n = 1'b1;
  endtask

  initial begin
    int r;
    int t0;
    int m0;
    epb_rst_n   = 1'b0;
    mmcm_locked = 1'b0;
    idelay_rdy  = 1'b0;
`ifdef RST_SEQ_SOFT_RST_EN
    soft_rst_req = 1'b0;
`endif

    // Nominal bring-up. Latency is 1 (RESET) + 2 (sync) + LS (stable) to IDLY_RST.
    apply_reset(1'b1, 1'b1);
    r  = cyc;
    m0 = mmcm_hi;
    sb_push(int'(LS) + 3);
    wait_lvl("nom_idly_rise", 1, 1'b1, 40);
    sb_check("nom_idly_latency", cyc - r);
    t0 = cyc;
    sb_push(int'(IR));
    wait_lvl("nom_idly_fall", 1, 1'b0, 20);
    sb_check("nom_idly_width", cyc - t0);
    t0 = cyc;
    sb_push(1);
    wait_lvl("nom_ready", 3, 1'b1, 10);
    sb_check("nom_ready_latency", cyc - t0);
    sb_push(0); sb_check("nom_sys_rst", int'(sys_rst));
    sb_push(0); sb_check("nom_mmcm_never", mmcm_hi - m0);

    // Lock timeout: WAIT_LOCK lasts LT cycles, then mmcm_rst is high for MR cycles.
    apply_reset(1'b0, 1'b1);
    r = cyc;
    sb_push(int'(LT) + 1);
    wait_lvl("to_mmcm_rise", 0, 1'b1, 60);
    sb_check("to_first_latency", cyc - r);
    for (int k = 0; k < 2; k++) begin
      t0 = cyc;
      sb_push(int'(MR));
      wait_lvl("to_mmcm_fall", 0, 1'b0, 20);
      sb_check("to_mmcm_width", cyc - t0);
      sb_push(int'(LT + MR));
      wait_lvl("to_mmcm_rerise", 0, 1'b1, 60);
      sb_check("to_mmcm_period", cyc - t0);
    end
    wait_lvl("to_mmcm_fall_last", 0, 1'b0, 20);
    mmcm_locked = 1'b1;
    wait_lvl("to_ready", 3, 1'b1, 80);
    sb_push(0); sb_check("to_sys_rst", int'(sys_rst));
    sb_push(0); sb_check("to_lock_loss", int'(lock_loss_cnt));

    // Glitchy lock: a one-cycle drop at stable count 5 restarts qualification.
    // The drop reaches WAIT_LOCK after 3 edges, lock returns one edge later, then LS cycles.
    apply_reset(1'b1, 1'b1);
    tick(8);
    t0 = cyc;
    mmcm_locked = 1'b0;
    tick(1);
    mmcm_locked = 1'b1;
    sb_push(4 + int'(LS));
    wait_lvl("gl_idly_rise", 1, 1'b1, 40);
    sb_check("gl_idly_latency", cyc - t0);
    sb_push(1); sb_check("gl_at_least_stable", int'((cyc - t0) >= int'(LS)));
    wait_lvl("gl_ready", 3, 1'b1, 40);

    // Lock loss in RUN, repeated until the count saturates.
    for (int i = 0; i < 300; i++) begin
      if (i > 0) begin
        mmcm_locked = 1'b1;
        wait_lvl("ll_relock", 3, 1'b1, 60);
      end
      mmcm_locked = 1'b0;
      tick(3);
      if (i == 0) begin
        sb_push(1); sb_check("ll_sys_rst_3edges", int'(sys_rst));
        sb_push(0); sb_check("ll_ready_3edges", int'(ready));
      end
      sb_push((i < 255) ? i + 1 : 255);
      sb_check("ll_count", int'(lock_loss_cnt));
    end
    mmcm_locked = 1'b1;
    wait_lvl("ll_final_ready", 3, 1'b1, 60);
    sb_push(255); sb_check("ll_saturated", int'(lock_loss_cnt));

    // Ready loss in RUN re-enters IDLY_RST through the synchroniser.
    idelay_rdy = 1'b0;
    tick(3);
    sb_push(0); sb_check("rl_ready", int'(ready));
    sb_push(1); sb_check("rl_idelay_rst", int'(idelay_rst));
    idelay_rdy = 1'b1;
    wait_lvl("rl_ready_back", 3, 1'b1, 40);

    // Ready timeout: idelay_rst is high IR cycles and repeats every IR+RT cycles.
    apply_reset(1'b1, 1'b0);
    wait_lvl("rt_idly_rise", 1, 1'b1, 40);
    for (int k = 0; k < 2; k++) begin
      t0 = cyc;
      sb_push(int'(IR));
      wait_lvl("rt_idly_fall", 1, 1'b0, 20);
      sb_check("rt_idly_width", cyc - t0);
      sb_push(int'(IR + RT));
      wait_lvl("rt_idly_rerise", 1, 1'b1, 40);
      sb_check("rt_idly_period", cyc - t0);
    end
    idelay_rdy = 1'b1;
    wait_lvl("rt_ready", 3, 1'b1, 40);
    sb_push(0); sb_check("rt_sys_rst", int'(sys_rst));

    // Asynchronous reset in the middle of IDLY_RST drops idelay_rst immediately.
    idelay_rdy = 1'b0;
    wait_lvl("ar_idly_rise", 1, 1'b1, 10);
    #2;
    epb_rst_n = 1'b0;
    #1;
    sb_push(0); sb_check("ar_idelay_rst", int'(idelay_rst));
    sb_push(1); sb_check("ar_sys_rst", int'(sys_rst));
    sb_push(0); sb_check("ar_ready", int'(ready));

`ifdef RST_SEQ_SOFT_RST_EN
    // Soft reset from RUN: an MMCM reset pulse, with the lock-loss count unchanged.
    apply_reset(1'b1, 1'b1);
    wait_lvl("sr_ready0", 3, 1'b1, 40);
    mmcm_locked = 1'b0;
    tick(3);
    mmcm_locked = 1'b1;
    wait_lvl("sr_ready1", 3, 1'b1, 60);
    sb_push(1); sb_check("sr_count_before", int'(lock_loss_cnt));
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    t0 = cyc;
    sb_push(1); sb_check("sr_mmcm_rst", int'(mmcm_rst));
    sb_push(1); sb_check("sr_sys_rst", int'(sys_rst));
    sb_push(0); sb_check("sr_ready", int'(ready));
    sb_push(int'(MR));
    wait_lvl("sr_mmcm_fall", 0, 1'b0, 20);
    sb_check("sr_mmcm_width", cyc - t0);
    wait_lvl("sr_ready2", 3, 1'b1, 60);
    sb_push(1); sb_check("sr_count_after", int'(lock_loss_cnt));
`endif

    check_eq("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Power-on and lock-loss reset sequencer that sits at the consuming end of the clock infrastructure's MMCM lock and IDELAYCTRL ready outputs.
- Runs on the free-running EPB clock, so it keeps operating while the MMCM is unlocked or held in reset.
- Sequence: wait for MMCM lock → qualify lock → pulse idelay_rst → wait for idelay_rdy → release system reset.
- Retries by resetting the MMCM if lock never arrives; counts lock-loss events for software.

Parameters:
- LOCK_STABLE_CYCLES, 1024, cycles lock must stay continuously high before it is accepted.
- LOCK_TIMEOUT_CYCLES, 65536, cycles spent waiting for lock before mmcm_rst is issued.
- MMCM_RST_CYCLES, 16, width of the mmcm_rst pulse in cycles.
- IDELAY_RST_CYCLES, 16, width of the idelay_rst pulse in cycles.
- RDY_TIMEOUT_CYCLES, 4096, cycles spent waiting for idelay_rdy before re-pulsing idelay_rst.

Ports:
- epb_clk  input  1  free-running clock; all logic is in this domain.
- epb_rst_n  input  1  asynchronous, active-low reset.
- mmcm_locked  input  1  MMCM lock, asynchronous to epb_clk.
- idelay_rdy  input  1  IDELAYCTRL ready, asynchronous to epb_clk.
- soft_rst_req  input  1  single-cycle software reset request; present only with the optional feature.
- mmcm_rst  output  1  active-high MMCM reset.
- idelay_rst  output  1  active-high IDELAYCTRL reset.
- sys_rst  output  1  active-high system reset; consumers re-synchronise it into their own domains.
- ready  output  1  high only in RUN.
- lock_loss_cnt  output  8  saturating count of lock losses seen in RUN.

Behaviour:
- Input synchronisation: mmcm_locked and idelay_rdy each pass through 2-flop synchronisers (lock_s, rdy_s), adding 2 cycles of latency.
- Reset state (epb_rst_n low): state=RESET, mmcm_rst=0, idelay_rst=0, sys_rst=1, ready=0, lock_loss_cnt=0, counter=0, synchronisers=0.
- All outputs are Moore outputs decoded from the state register. There is no combinational path from any input to any output.
- A single shared counter is cleared on every state change.
- RESET: → WAIT_LOCK on the first clock after reset release.
- WAIT_LOCK:
  - lock_s=1 → STABLE.
  - Otherwise the counter increments; when counter==LOCK_TIMEOUT_CYCLES-1 → MMCM_RST.
- MMCM_RST:
  - mmcm_rst=1 for exactly MMCM_RST_CYCLES cycles, then → WAIT_LOCK.
  - lock_s is ignored in this state.
- STABLE:
  - lock_s=0 → WAIT_LOCK.
  - When counter==LOCK_STABLE_CYCLES-1 with lock_s=1 → IDLY_RST.
- IDLY_RST:
  - idelay_rst=1 for exactly IDELAY_RST_CYCLES cycles, then → WAIT_RDY.
  - lock_s=0 → WAIT_LOCK, dropping idelay_rst immediately.
- WAIT_RDY:
  - lock_s=0 → WAIT_LOCK (takes priority).
  - Else rdy_s=1 → RUN.
  - Else when counter==RDY_TIMEOUT_CYCLES-1 → IDLY_RST (retry).
- RUN:
  - sys_rst=0, ready=1.
  - lock_s=0 → WAIT_LOCK, and lock_loss_cnt increments, saturating at 255.
  - rdy_s=0 with lock_s=1 → IDLY_RST.
- sys_rst is high in every state except RUN.
- Latency: a mmcm_locked falling edge reaches sys_rst=1 by the 3rd rising epb_clk edge.
- Asserting epb_rst_n mid-sequence forces all outputs to their reset values asynchronously; there is no partial-state retention.
- Counter is sized to hold max(all cycle parameters)-1. Each parameter must be ≥1.

Optional Feature:
- Macro RST_SEQ_SOFT_RST_EN.
- When defined:
  - soft_rst_req is a port.
  - soft_rst_req=1 in any state except RESET and MMCM_RST → MMCM_RST on the next edge; this overrides all other transitions.
  - lock_loss_cnt is not incremented by a soft reset.
- When not defined:
  - The port is absent and soft-reset logic is not built.
  - The state machine is otherwise identical.

Test Plan (bench params: LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MMCM_RST_CYCLES=4, IDELAY_RST_CYCLES=4, RDY_TIMEOUT_CYCLES=16):
- Nominal bring-up: release reset with mmcm_locked=1 and idelay_rdy=1 → idelay_rst high exactly 4 cycles, then ready=1 and sys_rst=0; mmcm_rst stays 0 throughout.
- Lock timeout: hold mmcm_locked=0 → mmcm_rst pulses 4 cycles every 32+4 cycles. Raise lock later → normal sequence completes.
- Glitchy lock: drop lock for 1 cycle at stable count 5 → STABLE restarts and the total time to idelay_rst is ≥8 cycles after the glitch. A 1-cycle glitch shorter than the synchroniser may be filtered; check against sampled lock_s.
- Lock loss in RUN: drop mmcm_locked → sys_rst=1 and ready=0 within 3 edges, lock_loss_cnt goes 0→1. Repeat 300 times → lock_loss_cnt saturates at 255.
- Ready timeout: hold idelay_rdy=0 → idelay_rst re-pulses 4 cycles every 4+16 cycles. Raise rdy → RUN.
- With RST_SEQ_SOFT_RST_EN: a 1-cycle soft_rst_req in RUN → mmcm_rst pulses 4 cycles, sys_rst=1, lock_loss_cnt unchanged. An async epb_rst_n assertion mid-IDLY_RST → idelay_rst=0 immediately.
